bcm_lut_pipe: RTL

//  Parametrised, pipelined, run-time reprogrammable code converter. Maps an IN_W-bit input

---
 rtl/bcm_lut_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bcm_lut_pipe.sv
// bcm_lut_pipe: two-stage valid/ready code converter through a register LUT that can be
// host-written and reloaded from INIT. Define CONV_PARITY_EN to add the registered out_par output.
module bcm_lut_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2,
  parameter logic [OUT_W*(2**IN_W)-1:0] INIT = 16'h0F3F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             wr_en,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             reload,
  output logic             busy
`ifdef CONV_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int DEPTH = 2**IN_W;

  typedef enum logic {
    S_IDLE,
    S_RELOAD
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IN_W:0]    r_cnt;
  logic [OUT_W-1:0] r_lut [DEPTH];
  logic             r_a_valid;
  logic [IN_W-1:0]  r_a_data;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
`ifdef CONV_PARITY_EN
  logic             r_out_par;
`endif

  logic             w_idle;
  logic             w_adv_b;
  logic             w_xfer;
  logic             w_accept;
  logic             w_wr_do;
  logic             w_last;
  logic [OUT_W-1:0] w_init_entry;
  logic [OUT_W-1:0] w_lookup;

  assign w_idle   = (r_state == S_IDLE);
  assign w_adv_b  = !r_out_valid || out_ready;
  assign w_xfer   = r_a_valid && w_adv_b && w_idle;
  assign in_ready = w_idle && (!r_a_valid || w_xfer);
  assign w_accept = in_valid && in_ready;
  // A reload request in the same cycle takes priority over a host write.
  assign w_wr_do  = wr_en && w_idle && !reload;
  assign w_last   = (r_cnt == (IN_W+1)'(DEPTH-1));

  assign busy      = (r_state == S_RELOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`ifdef CONV_PARITY_EN
  assign out_par   = r_out_par;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (reload) w_state_next = S_RELOAD;
      S_RELOAD: if (w_last) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_RELOAD) begin
      r_cnt <= w_last ? '0 : r_cnt + (IN_W+1)'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    w_init_entry = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_cnt[IN_W-1:0] == IN_W'(k)) w_init_entry = INIT[k*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_lut[k] <= INIT[k*OUT_W +: OUT_W];
    end else if (r_state == S_RELOAD) begin
      r_lut[r_cnt[IN_W-1:0]] <= w_init_entry;
    end else if (w_wr_do) begin
      r_lut[wr_addr] <= wr_data;
    end
  end

  // Write-first: a lookup on the edge that writes the same entry sees the new value.
  assign w_lookup = (w_wr_do && (wr_addr == r_a_data)) ? wr_data : r_lut[r_a_data];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_data  <= in_data;
    end else if (w_xfer) begin
      r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
`ifdef CONV_PARITY_EN
      r_out_par   <= 1'b0;
`endif
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_lookup;
`ifdef CONV_PARITY_EN
      r_out_par   <= ^w_lookup;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
